// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point add/subtract saturating pipeline.
//   sat_max / sat_min : two's-complement clamp limits for a W-bit sample,
//                       returned in a 64-bit container (slice to width).
//   OVF_POS / OVF_NEG : top-two-bit codes of the W+1 bit extended result
//                       that indicate positive / negative overflow.
//   lane_lo           : LSB index of a lane inside a packed lane vector.
package fixed_point_pkg;

    localparam logic [1:0] OVF_POS = 2'b01;
    localparam logic [1:0] OVF_NEG = 2'b10;

    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bitwise complement of 2^(w-1)-1 is -2^(w-1), sign-extended to 64 bits.
    function automatic logic [63:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/fixed_point_sat_lane.sv
// Combinational per-lane helpers for the add/subtract saturating pipeline.
//   i_a, i_b, i_sub -> o_ext : stage-1 extend, (W+1)-bit exact a+b or a-b.
//   i_ext -> o_res, o_sat    : stage-2 clamp of a registered extended value.
module fixed_point_sat_lane
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH:0]   o_ext,
    input  logic [WIDTH:0]   i_ext,
    output logic [WIDTH-1:0] o_res,
    output logic             o_sat
);

    localparam logic [63:0]      MAX64   = sat_max(WIDTH);
    localparam logic [63:0]      MIN64   = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = MIN64[WIDTH-1:0];

    logic [WIDTH:0] w_a_x;
    logic [WIDTH:0] w_b_x;

    assign w_a_x = {i_a[WIDTH-1], i_a};
    assign w_b_x = {i_b[WIDTH-1], i_b};

    // One guard bit is enough: the exact sum/difference of two W-bit values
    // always fits in W+1 bits, including a - (-2^(W-1)).
    always_comb begin
        o_ext = i_sub ? (w_a_x - w_b_x) : (w_a_x + w_b_x);
    end

    always_comb begin
        o_res = i_ext[WIDTH-1:0];
        o_sat = 1'b0;
        case (i_ext[WIDTH:WIDTH-1])
            OVF_POS: begin
                o_res = SAT_MAX;
                o_sat = 1'b1;
            end
            OVF_NEG: begin
                o_res = SAT_MIN;
                o_sat = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fixed_point_addsub_sat_pipe.sv
// Multi-lane two-stage saturating adder/subtractor with valid/ready flow.
//   clk, reset_n        : rising-edge clock, async active-low reset.
//   in_valid/in_ready   : input handshake; sub, a, b captured on transfer.
//   out_valid/out_ready : output handshake; sum, sat held while stalled.
//   sat_count, sat_clr  : saturating count of output transfers with any
//                         sat bit; sat_clr (sync) wins over an increment.
module fixed_point_addsub_sat_pipe
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned SAT_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sub,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] sum,
    output logic [LANES-1:0]       sat,
    output logic [SAT_CNT_W-1:0]   sat_count,
    input  logic                   sat_clr
);

    localparam int unsigned EW = WIDTH + 1;

    logic                   r_s1_valid;
    logic [LANES*EW-1:0]    r_s1_e;
    logic                   r_s2_valid;
    logic [LANES*WIDTH-1:0] r_sum;
    logic [LANES-1:0]       r_sat;
    logic [SAT_CNT_W-1:0]   r_sat_count;

    logic [LANES*EW-1:0]    w_ext;
    logic [LANES*WIDTH-1:0] w_res;
    logic [LANES-1:0]       w_sat;
    logic                   w_adv1;
    logic                   w_adv2;
    logic                   w_out_fire;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            fixed_point_sat_lane #(.WIDTH(WIDTH)) u_lane (
                .i_a   (a[lane_lo(g, WIDTH) +: WIDTH]),
                .i_b   (b[lane_lo(g, WIDTH) +: WIDTH]),
                .i_sub (sub),
                .o_ext (w_ext[lane_lo(g, EW) +: EW]),
                .i_ext (r_s1_e[lane_lo(g, EW) +: EW]),
                .o_res (w_res[lane_lo(g, WIDTH) +: WIDTH]),
                .o_sat (w_sat[g])
            );
        end
    endgenerate

    assign w_adv2     = !r_s2_valid || out_ready;
    assign w_adv1     = !r_s1_valid || w_adv2;
    assign w_out_fire = r_s2_valid && out_ready;

    // Stage-1 data needs no reset: it is qualified by r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_adv1) begin
            r_s1_e <= w_ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_sat      <= '0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                r_sum      <= w_res;
                r_sat      <= w_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (w_out_fire && (|r_sat) && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + SAT_CNT_W'(1);
        end
    end

    assign in_ready  = w_adv1;
    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign sat       = r_sat;
    assign sat_count = r_sat_count;

endmodule

// File: doc/fixed_point_addsub_sat_pipe.md
Name: fixed_point_addsub_sat_pipe

Overview:
- Parametrised, multi-lane, two-stage pipelined saturating adder/subtractor for two's-complement fixed-point samples.
- Handles LANES independent lanes per transfer, with a per-transfer add/subtract mode.
- Uses valid/ready handshakes on both sides, so it can sit between spectrum/FFT stages that may stall.
- Provides per-lane saturation flags and a sticky saturation-event counter for debug.

Parameters:
- WIDTH, 16: sample width in bits, two's complement; minimum 2.
- LANES, 4: number of independent lanes per transfer; minimum 1.
- SAT_CNT_W, 16: width of the saturation-event counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transfer offered.
- in_ready  out  1  block can accept; a transfer occurs when in_valid && in_ready.
- sub  in  1  0: A+B, 1: A-B; applies to all lanes of the transfer.
- a  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- b  in  LANES*WIDTH  same packing as a.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- sum  out  LANES*WIDTH  saturated results, same packing as a.
- sat  out  LANES  lane i saturated (either direction) in this result.
- sat_count  out  SAT_CNT_W  number of output transfers with any sat bit set.
- sat_clr  in  1  synchronous clear of sat_count.

Behaviour:
- Reset (reset_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, sum=0, sat=0, sat_count=0.
  - in_ready is combinational and therefore reads 1 while in reset.
  - Data registers other than the outputs may be left unreset.
  - Reset mid-operation discards all in-flight data and produces no output transfer.
- Stage 1 (extend), per lane:
  - e = {a_i[W-1],a_i} + {b_i[W-1],b_i} when sub=0, or {a_i[W-1],a_i} - {b_i[W-1],b_i} when sub=1.
  - Computed at full WIDTH+1 bits, so there is no intermediate wrap; b = -2^(W-1) with sub=1 is handled exactly.
  - Registers e and s1_valid.
- Stage 2 (saturate), per lane, using the top two bits of e:
  - 2'b01: result = 2^(W-1)-1 (0x7FFF for W=16), sat_i=1.
  - 2'b10: result = -2^(W-1) (0x8000), sat_i=1.
  - Otherwise: result = e[W-1:0], sat_i=0.
  - Registers sum, sat and out_valid (equal to s2_valid).
- Flow control:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational, no dependence on in_valid).
  - Stage 1 loads when adv1; s1_valid <= in_valid.
  - Stage 2 loads when adv2; s2_valid <= s1_valid.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready stays high.
- Throughput: 1 transfer/cycle with out_ready high.
- Stall rules:
  - While out_valid && !out_ready, sum, sat and out_valid must hold stable.
  - The pipeline holds up to 2 transfers; in_ready drops only when both stages are full and out_ready=0.
  - No data is dropped or duplicated.
- sat_count:
  - Increments by 1 on each output transfer where |sat is true.
  - Saturates at 2^SAT_CNT_W-1 and does not wrap.
  - sat_clr has priority: if sat_clr and an increment occur in the same cycle, the result is 0.
- sub is captured with the data; changing it while stalled does not affect already-accepted transfers.

Decomposition:
- Shared package (fixed_point_pkg), contents:
  - function sat_max(W) = 2^(W-1)-1.
  - function sat_min(W) = -2^(W-1).
  - localparam for the overflow codes 2'b01/2'b10.
  - lane-slice helper macro or function.
- One natural sub-module: fixed_point_sat_lane.
  - Combinational per-lane extend-and-saturate helpers (extend for stage 1, saturate for stage 2).
  - Instantiated LANES times via generate.
  - The top level owns all pipeline registers, handshake and counter.

Test Plan (WIDTH=16, LANES=4):
1. Reset then streaming: reset_n low 3 cycles, release, out_ready=1, send sub=0, a={1,2,3,4}, b={10,20,30,40} -> 2 cycles later out_valid=1, sum={11,22,33,44}, sat=0, sat_count=0.
2. Saturation both directions: lane0 0x7000+0x2000, lane1 0x8000+0xF000, lane2 0x8000-0x0001, lane3 0x0000-0x8000 (sub=1 for lanes 2-3 via separate transfers) -> results 0x7FFF sat, 0x8000 sat, 0x8000 sat, 0x7FFF sat; sat_count increments once per transfer.
3. Backpressure: continuous in_valid with a counting ramp, out_ready pattern 1,0,0,1,0,1... -> in_ready drops only after 2 held transfers, output sequence equals input sequence with no gaps or duplicates, sum stable while stalled.
4. Counter edges: SAT_CNT_W=2, 5 saturating transfers -> sat_count=3 and holds. Then sat_clr asserted in the same cycle as a saturating output transfer -> sat_count=0.
5. Async reset mid-flight: 2 transfers in the pipeline, stall, pulse reset_n low between clock edges -> out_valid=0, sat_count=0 immediately (before the next clk edge), no stale output after release.
6. Random regression: 10k random a/b/sub with random in_valid/out_ready, compared against a reference model computing clamp(a±b) -> exact match on sum, sat and sat_count.
